sample_frame_scheduler: RTL and testbench
=========================================

Name: sample_frame_scheduler

Overview:
- Generates the audio sample-rate strobe from clk_100mhz and, once per sample period, sequences the shared voice-mixer datapath through every enabled voice slot.
- Uses a req/ack handshake per voice, accumulates the signed voice samples, then saturates the sum and presents one mixed sample to the audio output stage.
- Sits between the tracker voice engines (requesters of the shared mixer) and the DAC/I2S serializer.

Parameters:
- DIV, 2083, clk_100mhz cycles per sample period (100 MHz / 2083 ≈ 48.01 kHz); must be >= NUM_VOICES*2+4.
- NUM_VOICES, 4, number of voice slots scheduled per frame; 1..16.
- VOICE_W, 16, width of the signed per-voice sample.
- OUT_W, 16, width of the signed mixed output sample.

Ports:
- clk_100mhz  in  1  system clock, 100 MHz.
- reset_n  in  1  asynchronous, active-low reset.
- enable  in  1  when 0, no new sample strobes are generated.
- voice_mask  in  NUM_VOICES  bit v=1 includes voice v in the frame; sampled at frame start.
- voice_req  out  1  request to the mixer datapath for voice voice_idx.
- voice_idx  out  clog2(NUM_VOICES) (min 1)  index of the voice being requested.
- voice_ack  in  1  datapath has voice_sample valid for voice_idx.
- voice_sample  in  VOICE_W  signed sample, valid when voice_ack=1.
- sample_out  out  OUT_W  signed mixed sample, held between frames.
- sample_valid  out  1  one-cycle pulse when sample_out updates.
- busy  out  1  high from frame start until the sample_valid cycle inclusive.
- overrun  out  1  sticky: a strobe arrived while busy.
- overrun_clr  in  1  clears overrun (a new overrun event in the same cycle wins).

Behaviour:
- Reset (reset_n=0, asynchronous): divider count=0, FSM=IDLE, accumulator=0, voice_req=0, voice_idx=0, sample_out=0, sample_valid=0, busy=0, overrun=0.
- Divider: counts 0..DIV-1 while enable=1 and wraps to 0; strobe is asserted for one cycle when count==DIV-1. When enable=0, the count is held at 0 and no strobe occurs; a frame already in progress still completes.
- Accumulator: signed, width ACC_W = VOICE_W + clog2(NUM_VOICES) + 1; sign-extends each voice_sample, so the sum never overflows.
- FSM states: IDLE, SCAN, REQ, SAT.
  - IDLE: on strobe, latch voice_mask, clear accumulator, set voice pointer p=0, busy=1, go to SCAN.
  - SCAN: if p==NUM_VOICES, go to SAT. Else if mask[p]=0, increment p and stay in SCAN (one cycle per skipped voice). Else drive voice_idx=p, voice_req=1, and go to REQ.
  - REQ: voice_req stays 1 and voice_idx stays stable until voice_ack=1. On the ack cycle, accumulator += voice_sample, p++, and go to SCAN; voice_req is 0 from the next cycle. voice_ack is ignored when voice_req=0. No timeout.
  - SAT: clamp the accumulator to [-2^(OUT_W-1), 2^(OUT_W-1)-1] and register it into sample_out. sample_valid=1 for this one cycle, busy=1. Next cycle: busy=0, go to IDLE.
- Latency with all voices enabled and ack returned 1 cycle after req rises: frame start to sample_valid = 3*NUM_VOICES + 2 cycles.
- Overrun: a strobe in any state other than IDLE sets overrun. That strobe is dropped (no queued frame) and the current frame continues unaffected. A strobe in the same cycle as the SAT→IDLE transition is also dropped and counts as an overrun.
- All voices masked: the frame still runs SCAN×NUM_VOICES, then SAT, producing sample_out=0 and a sample_valid pulse.
- voice_mask changes mid-frame have no effect until the next frame.
- Reset asserted mid-frame: all state returns to reset values immediately; no sample_valid is produced.

Test Plan:
- DIV=20, NUM_VOICES=4, enable=1, mask=4'hF, ack 1 cycle after req, samples 100,200,-50,7 -> voice_idx sequence 0,1,2,3; sample_out=257; sample_valid every 20 cycles; busy high 14 cycles per frame.
- mask=4'b0101, samples v0=1000, v2=-3000 -> no req for idx 1 or 3; sample_out=-2000.
- All four samples=32767 -> sample_out=32767 (saturated). All four samples=-32768 -> sample_out=-32768.
- DIV=20, ack delayed 10 cycles per voice -> strobe arrives while busy; overrun=1; no extra sample_valid; pulse overrun_clr -> overrun=0.
- enable deasserted mid-frame -> frame completes with one sample_valid; no further strobes; re-enable -> first sample_valid 20+14 cycles later.
- reset_n pulsed low while in REQ -> voice_req, busy, sample_out, and overrun all 0 asynchronously; the next frame starts only after a full DIV count.

Source files
------------

// File: rtl/sample_frame_scheduler_if.sv
// Voice-mixer request/acknowledge bus shared between the frame scheduler
// (master) and the voice datapath (slave).
interface sample_frame_scheduler_if #(
  parameter int NUM_VOICES = 4,
  parameter int VOICE_W    = 16
);
  localparam int IDX_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;

  logic               voice_req;
  logic [IDX_W-1:0]   voice_idx;
  logic               voice_ack;
  logic [VOICE_W-1:0] voice_sample;

  modport master (
    output voice_req,
    output voice_idx,
    input  voice_ack,
    input  voice_sample
  );

  modport slave (
    input  voice_req,
    input  voice_idx,
    output voice_ack,
    output voice_sample
  );
endinterface

// File: rtl/sample_frame_scheduler.sv
// Sample-rate strobe generator plus per-frame voice sequencer: walks the enabled
// voices over a req/ack bus, sums their samples and emits one saturated mix.
module sample_frame_scheduler #(
  parameter int DIV        = 2083,
  parameter int NUM_VOICES = 4,
  parameter int VOICE_W    = 16,
  parameter int OUT_W      = 16
) (
  input  logic                       clk_100mhz,
  input  logic                       reset_n,
  input  logic                       enable,
  input  logic [NUM_VOICES-1:0]      voice_mask,
  sample_frame_scheduler_if.master   mix,
  output logic [OUT_W-1:0]           sample_out,
  output logic                       sample_valid,
  output logic                       busy,
  output logic                       overrun,
  input  logic                       overrun_clr
);
  localparam int IDX_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
  localparam int PTR_W = $clog2(NUM_VOICES + 1);
  localparam int ACC_W = VOICE_W + $clog2(NUM_VOICES) + 1;
  localparam int EXT_W = (ACC_W > OUT_W) ? ACC_W : OUT_W;
  localparam int CNT_W = $clog2(DIV);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);
  localparam logic [PTR_W-1:0] PTR_END  = PTR_W'(NUM_VOICES);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic signed [EXT_W-1:0] SAT_MAX =
    {{(EXT_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [EXT_W-1:0] SAT_MIN =
    {{(EXT_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    REQ  = 2'd2,
    SAT  = 2'd3
  } state_e;

  // Clamp the wide accumulator into the signed output range.
  function automatic logic [OUT_W-1:0] saturate(input logic signed [ACC_W-1:0] a);
    logic signed [EXT_W-1:0] x;
    x = EXT_W'(a);
    if (x > SAT_MAX) begin
      saturate = SAT_MAX[OUT_W-1:0];
    end else if (x < SAT_MIN) begin
      saturate = SAT_MIN[OUT_W-1:0];
    end else begin
      saturate = x[OUT_W-1:0];
    end
  endfunction

  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    strobe_s;
  state_e                  state_q;
  logic [NUM_VOICES-1:0]   mask_q;
  logic [PTR_W-1:0]        ptr_q;
  logic signed [ACC_W-1:0] acc_q;
  logic                    req_q;
  logic [IDX_W-1:0]        idx_q;
  logic [OUT_W-1:0]        sample_out_q;
  logic                    sample_valid_q;
  logic                    busy_q;
  logic                    overrun_q;
  logic                    cur_en_s;

  assign strobe_s = enable && (cnt_q == CNT_LAST);
  assign cur_en_s = mask_q[ptr_q[IDX_W-1:0]];

  // Divider next count: held at zero while disabled, wraps after DIV-1.
  always_comb begin
    cnt_d = cnt_q;
    if (!enable) begin
      cnt_d = '0;
    end else if (strobe_s) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CNT_ONE;
    end
  end

  // Divider count register.
  always_ff @(posedge clk_100mhz or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Sticky overrun: a strobe that lands outside IDLE is dropped and flagged; a new event beats clear.
  always_ff @(posedge clk_100mhz or negedge reset_n) begin
    if (!reset_n) begin
      overrun_q <= 1'b0;
    end else if (strobe_s && (state_q != IDLE)) begin
      overrun_q <= 1'b1;
    end else if (overrun_clr) begin
      overrun_q <= 1'b0;
    end else begin
      overrun_q <= overrun_q;
    end
  end

  // Frame sequencer with registered bus and output signals.
  always_ff @(posedge clk_100mhz or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= IDLE;
      mask_q         <= '0;
      ptr_q          <= '0;
      acc_q          <= '0;
      req_q          <= 1'b0;
      idx_q          <= '0;
      sample_out_q   <= '0;
      sample_valid_q <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      sample_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (strobe_s) begin
            mask_q  <= voice_mask;
            acc_q   <= '0;
            ptr_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= SCAN;
          end
        end
        SCAN: begin
          // The mix is registered on the way into SAT so sample_valid lines up with that state.
          if (ptr_q == PTR_END) begin
            sample_out_q   <= saturate(acc_q);
            sample_valid_q <= 1'b1;
            state_q        <= SAT;
          end else if (!cur_en_s) begin
            ptr_q <= ptr_q + PTR_ONE;
          end else begin
            idx_q   <= ptr_q[IDX_W-1:0];
            req_q   <= 1'b1;
            state_q <= REQ;
          end
        end
        REQ: begin
          if (mix.voice_ack) begin
            acc_q   <= acc_q + ACC_W'($signed(mix.voice_sample));
            ptr_q   <= ptr_q + PTR_ONE;
            req_q   <= 1'b0;
            state_q <= SCAN;
          end
        end
        SAT: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          req_q   <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign mix.voice_req = req_q;
  assign mix.voice_idx = idx_q;
  assign sample_out    = sample_out_q;
  assign sample_valid  = sample_valid_q;
  assign busy          = busy_q;
  assign overrun       = overrun_q;
endmodule

// File: tb/tb_sample_frame_scheduler.sv
// Directed bench for sample_frame_scheduler: a voice-datapath responder, a
// scoreboard of expected mixes and latency/overrun/reset checks.
module tb_sample_frame_scheduler;
  localparam int DIV       = 20;
  localparam int NV        = 4;
  localparam int VW        = 16;
  localparam int OW        = 16;
  localparam int BUSY_FULL = 3 * NV + 2;
  localparam int START_LAT = DIV + BUSY_FULL - 1;

  logic          clk_100mhz  = 1'b0;
  logic          reset_n     = 1'b0;
  logic          enable      = 1'b0;
  logic          overrun_clr = 1'b0;
  logic [NV-1:0] voice_mask  = '0;
  logic [OW-1:0] sample_out;
  logic          sample_valid;
  logic          busy;
  logic          overrun;

  sample_frame_scheduler_if #(.NUM_VOICES(NV), .VOICE_W(VW)) bus ();

  sample_frame_scheduler #(.DIV(DIV), .NUM_VOICES(NV), .VOICE_W(VW), .OUT_W(OW)) dut (
    .clk_100mhz  (clk_100mhz),
    .reset_n     (reset_n),
    .enable      (enable),
    .voice_mask  (voice_mask),
    .mix         (bus),
    .sample_out  (sample_out),
    .sample_valid(sample_valid),
    .busy        (busy),
    .overrun     (overrun),
    .overrun_clr (overrun_clr)
  );

  int errors = 0, checks = 0, cyc = 0;
  int samples[NV];
  int ack_dly = 1;
  int idx_code = 0;
  int exp_q[$];
  int valid_cnt = 0, valid_cyc = 0, busy_run = 0, busy_len = 0;
  int t0, t1, vc;

  initial forever #5 clk_100mhz = ~clk_100mhz;

  always @(posedge clk_100mhz) cyc <= cyc + 1;

  task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) begin
      @(posedge clk_100mhz);
      #1;
    end
  endtask

  task automatic wait_valid(input string tag, input int bound);
    int start;
    int n;
    start = valid_cnt;
    n = 0;
    while (valid_cnt == start && n < bound) begin
      @(posedge clk_100mhz);
      #1;
      n++;
    end
    check({tag, "_seen"}, int'(valid_cnt != start), 1);
  endtask

  // Voice datapath: ack ack_dly cycles after req is seen, encode the served index order.
  initial begin
    int cnt;
    cnt = 0;
    bus.voice_ack = 1'b0;
    bus.voice_sample = '0;
    forever begin
      @(negedge clk_100mhz);
      if (!reset_n) begin
        bus.voice_ack = 1'b0;
        cnt = 0;
      end else if (bus.voice_ack) begin
        bus.voice_ack = 1'b0;
        cnt = 0;
      end else if (bus.voice_req) begin
        if (cnt >= ack_dly) begin
          bus.voice_ack = 1'b1;
          bus.voice_sample = 16'(samples[bus.voice_idx]);
          idx_code = idx_code * 16 + int'(bus.voice_idx) + 1;
        end else begin
          cnt++;
        end
      end
    end
  end

  // Output monitor: scoreboard pop on every sample_valid, busy run length tracking.
  initial forever begin
    @(negedge clk_100mhz);
    if (busy === 1'b1) busy_run++;
    else busy_run = 0;
    if (sample_valid === 1'b1) begin
      valid_cnt++;
      valid_cyc = cyc;
      busy_len = busy_run;
      check("busy_at_valid", busy, 1);
      check("valid_expected", int'(exp_q.size() > 0), 1);
      if (exp_q.size() > 0) check("sample_out", $signed(sample_out), exp_q.pop_front());
    end
  end

  initial begin
    samples = '{0, 0, 0, 0};
    wait_cycles(3);
    check("rst_req", bus.voice_req, 0);
    check("rst_idx", bus.voice_idx, 0);
    check("rst_busy", busy, 0);
    check("rst_sample_out", $signed(sample_out), 0);
    check("rst_valid", sample_valid, 0);
    check("rst_overrun", overrun, 0);

    // Full mask, two back-to-back frames
    samples = '{100, 200, -50, 7};
    voice_mask = 4'hF;
    idx_code = 0;
    exp_q.push_back(257);
    exp_q.push_back(257);
    reset_n = 1'b1;
    enable = 1'b1;
    t0 = cyc;
    wait_valid("f1", 100);
    check("f1_latency", valid_cyc - t0, START_LAT);
    check("f1_busy_len", busy_len, BUSY_FULL);
    check("f1_idx_seq", idx_code, 32'h1234);
    t1 = valid_cyc;
    idx_code = 0;
    wait_valid("f2", 100);
    check("f2_period", valid_cyc - t1, DIV);
    check("f2_idx_seq", idx_code, 32'h1234);

    // Sparse mask
    voice_mask = 4'b0101;
    samples = '{1000, 5, -3000, 5};
    idx_code = 0;
    exp_q.push_back(-2000);
    wait_valid("mask", 100);
    check("mask_idx_seq", idx_code, 32'h13);
    check("mask_busy_len", busy_len, 10);

    // Saturation both ways
    voice_mask = 4'hF;
    samples = '{32767, 32767, 32767, 32767};
    exp_q.push_back(32767);
    wait_valid("sat_pos", 100);
    samples = '{-32768, -32768, -32768, -32768};
    exp_q.push_back(-32768);
    wait_valid("sat_neg", 100);

    // All voices masked
    voice_mask = 4'h0;
    idx_code = 0;
    exp_q.push_back(0);
    wait_valid("none", 100);
    check("none_busy_len", busy_len, NV + 2);
    check("none_idx_seq", idx_code, 0);

    // Slow acks cause overrun
    voice_mask = 4'hF;
    samples = '{1, 2, 3, 4};
    ack_dly = 10;
    check("overrun_pre", overrun, 0);
    exp_q.push_back(10);
    wait_valid("slow", 200);
    check("slow_busy_len", busy_len, 4 * 12 + 2);
    check("overrun_set", overrun, 1);
    t1 = valid_cyc;
    ack_dly = 1;
    exp_q.push_back(10);
    wait_valid("after_ov", 100);
    check("after_ov_gap", valid_cyc - t1, 3 * DIV + BUSY_FULL - 50);
    check("overrun_sticky", overrun, 1);
    overrun_clr = 1'b1;
    wait_cycles(1);
    overrun_clr = 1'b0;
    check("overrun_clr", overrun, 0);

    // Disable mid-frame, then re-enable
    exp_q.push_back(10);
    t1 = 0;
    while (busy !== 1'b1 && t1 < 40) begin
      wait_cycles(1);
      t1++;
    end
    check("dis_busy_seen", busy, 1);
    enable = 1'b0;
    wait_valid("dis_frame", 100);
    vc = valid_cnt;
    wait_cycles(3 * DIV);
    check("dis_no_strobe", valid_cnt, vc);
    check("dis_idle", busy, 0);
    enable = 1'b1;
    t0 = cyc;
    exp_q.push_back(10);
    wait_valid("reen", 100);
    check("reen_latency", valid_cyc - t0, START_LAT);

    // Reset while a request is outstanding
    ack_dly = 10;
    t1 = 0;
    while (!(overrun === 1'b1 && bus.voice_req === 1'b1) && t1 < 100) begin
      wait_cycles(1);
      t1++;
    end
    check("pre_rst_overrun", overrun, 1);
    vc = valid_cnt;
    reset_n = 1'b0;
    #1;
    check("arst_req", bus.voice_req, 0);
    check("arst_busy", busy, 0);
    check("arst_sample_out", $signed(sample_out), 0);
    check("arst_overrun", overrun, 0);
    wait_cycles(3);
    check("arst_no_valid", valid_cnt, vc);
    ack_dly = 1;
    reset_n = 1'b1;
    t0 = cyc;
    exp_q.push_back(10);
    wait_valid("post_rst", 100);
    check("post_rst_latency", valid_cyc - t0, START_LAT);

    wait_cycles(5);
    check("queue_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
